seg7_count_display: RTL and testbench
=====================================

# seg7_count_display

Downstream display stage for the 8-bit LED up/down counter. Consumes the counter's `q` value, converts it to three BCD digits with a sequential shift-add-3 converter, and time-multiplexes the digits onto a common-anode 4-digit 7-segment display. It runs on the undivided board clock, independent of the counter's divided clock, and re-samples `q` continuously.

## Interface
Parameters:
- `SCAN_DIV`, 50000 — clock cycles each digit is lit; legal range ≥ 2.

Ports:
- `clk`  input  1  board clock; all state rises on posedge.
- `reset`  input  1  asynchronous, active-low; clears all state.
- `q`  input  8  unsigned count value from the counter stage; asynchronous to the display, sampled only in IDLE.
- `an`  output  4  digit enables, active-low; `an[0]` = ones, `an[1]` = tens, `an[2]` = hundreds, `an[3]` always 1.
- `seg`  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- `bcd`  output  12  last committed BCD value {hundreds, tens, ones}.
- `busy`  output  1  high while a conversion is in SHIFT or COMMIT.

## Operation
- Converter FSM states:
  - IDLE: one cycle. Latch `q` into an 8-bit shift register. Clear the 12-bit BCD accumulator and the bit counter. Go to SHIFT.
  - SHIFT: 8 cycles. On each cycle, first add 3 to every accumulator nibble ≥ 5, then left-shift {accumulator, shift register} by 1. Go to COMMIT after the 8th shift (bit counter = 7).
  - COMMIT: one cycle. `bcd` ← accumulator. Go to IDLE.
- Conversions run back to back. Period is 10 cycles.
- `q` changes during SHIFT or COMMIT have no effect until the next IDLE.
- `busy` = 1 in SHIFT and COMMIT, 0 in IDLE.
- Scan prescaler counts 0..SCAN_DIV-1 and wraps.
- At terminal count, the digit index advances 0→1→2→0. On the same edge, `an` and `seg` are updated for the new index.
- `an`/`seg` decode the current `bcd`. A digit code above 9 cannot occur; it decodes to blank (7'h7F).
- Ones digit is never blanked.

## Timing
- Reset values: `an`=4'b1111, `seg`=7'h7F, `bcd`=12'h000, `busy`=0, FSM=IDLE, prescaler=0, digit index=2, so the first terminal count selects ones.
- Reset mid-conversion aborts immediately. The partial result is discarded and `bcd` stays 0.
- Latency: `q` sampled at IDLE edge k appears on `bcd` at edge k+9.
- Worst-case `q`→`bcd` latency is 19 cycles.
- The first digit is lit at edge SCAN_DIV after reset release.
- Each digit is then lit for exactly SCAN_DIV cycles. Full refresh period is 3·SCAN_DIV.
- A `bcd` commit mid-slot changes `seg` only at the next slot boundary; `seg` is registered per slot.
- All outputs are registered. There are no combinational paths from `q`.

## Configuration
- `SEG7_LZ_BLANK_EN` defined:
  - hundreds digit blanked (7'h7F) when it is 0;
  - tens digit blanked when hundreds = 0 and tens = 0.
- Undefined: all three digits always shown, with leading zeros (digit 0 = 7'h40). The `an` pattern is unchanged either way.

## Structure
- Shared package `seg7_pkg`:
  - FSM state encodings (IDLE, SHIFT, COMMIT);
  - segment constants for digits 0–9 and blank;
  - digit-count constant (3).
- Sub-module `bin2bcd_seq`: the IDLE/SHIFT/COMMIT converter. Outputs `bcd` and `busy`.
- Top level holds the prescaler, digit index, blanking, and segment decode.

## Test plan
- `reset` low while in SHIFT with `q`=8'd255 → `an`=4'b1111, `seg`=7'h7F, `bcd`=0, `busy`=0 immediately, without waiting for a clock.
- `q`=8'd255 held, sampled at edge k → `busy` high edges k..k+8, `bcd`=12'h255 at edge k+9, next IDLE at k+10.
- SCAN_DIV=4, `q`=8'd7, macro defined → `an` cycles 1110/1101/1011 every 4 cycles; `seg`=7'h78 on ones, 7'h7F on tens and hundreds.
- Same stimulus as the previous case with the macro undefined → tens and hundreds `seg`=7'h40.
- `q`=8'd100, macro defined → hundreds `seg`=7'h79, tens 7'h40 (not blanked), ones 7'h40.
- `q` 8'd50→8'd200 on the third SHIFT cycle → that conversion commits 12'h050; the following conversion commits 12'h200.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment count display.
// Converter FSM states, active-low segment codes, digit indices.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  localparam int NUM_DIGITS = 3;

  localparam logic [1:0] DIG_ONES  = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_HUNDS = 2'd2;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 8-bit q -> 3 BCD digits, 10-cycle period.
// Ports: clk, reset (async active-low), q[7:0] in; bcd[11:0], busy out.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  q,
  output logic [11:0] bcd,
  output logic        busy
);

  conv_state_t state;
  conv_state_t state_nxt;

  logic [7:0]  sr;
  logic [11:0] acc;
  logic [2:0]  bit_cnt;
  logic [3:0]  tens_adj;
  logic [3:0]  ones_adj;

  assign tens_adj = add3(acc[7:4]);
  assign ones_adj = add3(acc[3:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   state_nxt = SHIFT;
      SHIFT:  if (bit_cnt == 3'd7)
                state_nxt = COMMIT;
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hundreds never exceeds 1 before the last shift of an
  // 8-bit value, so it needs no add-3 correction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      bcd     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          sr      <= q;
          acc     <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          acc     <= {acc[10:8], tens_adj,
                      ones_adj, sr[7]};
          sr      <= {sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        COMMIT: bcd <= acc;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/seg7_count_display.sv
// Counter display: BCD conversion + 3-digit multiplexed common-anode scan.
// Ports: clk, reset (async low), q[7:0]; an[3:0], seg[6:0], bcd[11:0], busy.
// Build macro SEG7_LZ_BLANK_EN blanks leading-zero hundreds/tens digits.
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  q,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int PW =
    (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST =
    PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic          tc;
  logic [1:0]    dig_idx;
  logic [1:0]    dig_nxt;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          blank_h;
  logic          blank_t;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .q     (q),
    .bcd   (bcd),
    .busy  (busy)
  );

`ifdef SEG7_LZ_BLANK_EN
  assign blank_h = (bcd[11:8] == 4'd0);
  assign blank_t = blank_h &&
                   (bcd[7:4] == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  assign tc = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  presc <= '0;
    else if (tc) presc <= '0;
    else         presc <= presc + PW'(1);
  end

  always_comb begin
    dig_nxt = (dig_idx == DIG_HUNDS) ?
              DIG_ONES : dig_idx + 2'd1;
  end

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_BLANK;
    unique case (1'b1)
      (dig_nxt == DIG_ONES): begin
        an_nxt  = 4'b1110;
        seg_nxt = seg_decode(bcd[3:0]);
      end
      (dig_nxt == DIG_TENS): begin
        an_nxt  = 4'b1101;
        seg_nxt = blank_t ? SEG_BLANK :
                  seg_decode(bcd[7:4]);
      end
      (dig_nxt == DIG_HUNDS): begin
        an_nxt  = 4'b1011;
        seg_nxt = blank_h ? SEG_BLANK :
                  seg_decode(bcd[11:8]);
      end
      default: ;
    endcase
  end

  // Index resets to hundreds so the first
  // terminal count lands on the ones digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig_idx <= DIG_HUNDS;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
    end else if (tc) begin
      dig_idx <= dig_nxt;
      an      <= an_nxt;
      seg     <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed self-checking bench for seg7_count_display, SCAN_DIV = 4.
// Expected leading-zero codes follow SEG7_LZ_BLANK_EN.
module tb_seg7_count_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  q;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [11:0] bcd;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  always #5 clk = ~clk;

  seg7_count_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q),
    .an    (an),
    .seg   (seg),
    .bcd   (bcd),
    .busy  (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [11:0] obs,
    input logic [11:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %h expected %h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    reset = 1'b0;
    q     = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",   12'(an),   12'hF);
    chk("rst_seg",  12'(seg),  12'h7F);
    chk("rst_bcd",  bcd,       12'h000);
    chk("rst_busy", 12'(busy), 12'h0);

    reset = 1'b1;
    cyc   = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("busy_conv", 12'(busy), 12'h1);
      chk("bcd_hold",  bcd,       12'h000);
      if (cyc == 3)
        chk("an_pre", 12'(an), 12'hF);
      if (cyc == 4) begin
        chk("an_first",  12'(an),  12'hE);
        chk("seg_first", 12'(seg), 12'h40);
      end
      if (cyc == 8) begin
        chk("an_t0",  12'(an),  12'hD);
        chk("seg_t0", 12'(seg), 12'(LZ));
      end
    end
    tick();
    chk("bcd_255",   bcd,       12'h255);
    chk("busy_idle", 12'(busy), 12'h0);
    tick();
    chk("busy_next", 12'(busy), 12'h1);
    tick();
    chk("an_h2",  12'(an),  12'hB);
    chk("seg_h2", 12'(seg), 12'h24);
    run_to(16);
    chk("an_o5",  12'(an),  12'hE);
    chk("seg_o5", 12'(seg), 12'h12);
    run_to(20);
    chk("an_t5",  12'(an),  12'hD);
    chk("seg_t5", 12'(seg), 12'h12);
    q = 8'd7;

    run_to(24);
    chk("seg_h2b", 12'(seg), 12'h24);
    run_to(28);
    chk("seg_o5b", 12'(seg), 12'h12);
    run_to(30);
    chk("bcd_007", bcd, 12'h007);
    run_to(31);
    chk("seg_midslot", 12'(seg), 12'h12);
    chk("an_midslot",  12'(an),  12'hE);
    run_to(32);
    chk("an_t7",  12'(an),  12'hD);
    chk("seg_t7", 12'(seg), 12'(LZ));
    run_to(33);
    chk("an_t7_hold", 12'(an), 12'hD);
    run_to(36);
    chk("an_h7",  12'(an),  12'hB);
    chk("seg_h7", 12'(seg), 12'(LZ));
    run_to(40);
    chk("an_o7",  12'(an),  12'hE);
    chk("seg_o7", 12'(seg), 12'h78);
    q = 8'd100;

    run_to(50);
    chk("bcd_100", bcd, 12'h100);
    run_to(52);
    chk("seg_o100", 12'(seg), 12'h40);
    run_to(56);
    chk("seg_t100", 12'(seg), 12'h40);
    run_to(60);
    chk("an_h100",  12'(an),  12'hB);
    chk("seg_h100", 12'(seg), 12'h79);
    q = 8'd50;

    run_to(63);
    chk("busy_shift3", 12'(busy), 12'h1);
    q = 8'd200;
    run_to(69);
    chk("bcd_pre050", bcd, 12'h100);
    run_to(70);
    chk("bcd_050", bcd, 12'h050);
    run_to(79);
    chk("bcd_050_hold", bcd, 12'h050);
    run_to(80);
    chk("bcd_200", bcd, 12'h200);
    q = 8'd255;

    run_to(83);
    chk("busy_pre_rst", 12'(busy), 12'h1);
    chk("seg_pre_rst",  12'(seg),  12'h12);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_an",   12'(an),   12'hF);
    chk("arst_seg",  12'(seg),  12'h7F);
    chk("arst_bcd",  bcd,       12'h000);
    chk("arst_busy", 12'(busy), 12'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_bcd", bcd, 12'h000);
    reset = 1'b1;
    q     = 8'd42;
    cyc   = 0;
    run_to(9);
    chk("bcd_042_pre", bcd, 12'h000);
    run_to(10);
    chk("bcd_042", bcd, 12'h042);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
